cordic_exp_seq: RTL and testbench
=================================

CORDIC_EXP_SEQ -- requirements
Module: cordic_exp_seq

Interface
REQ-001 SHALL have parameter W, default 22: total width of signed two's-complement input and output.
REQ-002 SHALL have parameter F, default 12: fractional bits; 1.0 = 2^F (4096 at default).
REQ-003 SHALL have parameter N, default 12: fractional shift-add iterations, N <= F.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  in  1: x is valid.
REQ-007 SHALL have port in_ready  out  1: block accepts x this cycle.
REQ-008 SHALL have port x  in  W: signed Q(W-F).F argument.
REQ-009 SHALL have port out_valid  out  1: result is valid.
REQ-010 SHALL have port out_ready  in  1: consumer takes the result.
REQ-011 SHALL have port y  out  W: signed Q(W-F).F result, e^x.
REQ-012 SHALL have port ovf  out  1: y saturated to the maximum positive value.
REQ-013 SHALL have port udf  out  1: true result rounded to 0.

Function
REQ-014 SHALL accept x when in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL use states IDLE -> FRAC -> INT -> DONE -> IDLE.
REQ-016 On accept SHALL split x by floor: n = x >>> F (arithmetic), r = x[F-1:0] unsigned in [0,1), acc = 2^F.
REQ-017 In FRAC, iteration i = 0..N-1 SHALL take one cycle each: if r >= LN[i] then r -= LN[i] and acc += acc >> i.
REQ-018 Entry i of LN SHALL be round(ln(1+2^-i) * 2^F).
REQ-019 FRAC SHALL use no multiplier.
REQ-020 acc SHALL be W+2 bits wide internally so that intermediates up to e^1 never wrap.
REQ-021 In INT, each cycle while n != 0 SHALL apply one step, using a W x W multiplier with truncation to F fractional bits:
- n > 0: acc = (acc * E_POS) >> F and n -= 1.
- n < 0: acc = (acc * E_NEG) >> F and n += 1.
REQ-022 E_POS SHALL be round(e * 2^F) = 11134 at default; E_NEG SHALL be round(e^-1 * 2^F) = 1507 at default.
REQ-023 INT SHALL terminate early in two cases:
- acc > 2^(W-1)-1: set ovf and force y = 2^(W-1)-1.
- acc == 0: set udf and force y = 0.
REQ-024 With n == 0 at the end of FRAC, INT SHALL be skipped and the FSM SHALL go straight to DONE.
REQ-025 Latency from accept to out_valid SHALL be exactly 1 + N + min(|n|, cycles to saturate or zero) + 1 cycles.
REQ-026 In DONE, out_valid=1 and y/ovf/udf SHALL hold stable until out_ready=1.
REQ-027 The DONE->IDLE transition SHALL occur on the cycle out_ready=1; in_ready SHALL rise the next cycle (no same-cycle accept).
REQ-028 x SHALL be sampled only at accept; later changes to x SHALL NOT affect an operation in flight.
REQ-029 Input range endpoints SHALL be handled:
- x = -2^(W-1) (most negative): result 0 with udf=1.
- x = 2^(W-1)-1: result saturated with ovf=1.
REQ-030 y SHALL be within +/-4 LSB of round(e^x * 2^F) for all non-saturated, non-zero results.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, in_ready=0 while asserted, out_valid=0, y=0, ovf=0, udf=0, and internal acc/r/n/i=0.
REQ-032 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no result ever presented.

Structure
REQ-034 Package cordic_pkg SHALL hold the state enum, the LN table generator (function of i and F), E_POS/E_NEG constant functions, and the Q-format width helpers.
REQ-035 One sub-module, cordic_exp_frac_step, SHALL implement the combinational compare/subtract/shift-add of REQ-017.
REQ-036 The FSM, counters and INT multiplier SHALL stay in cordic_exp_seq.

Verification
REQ-037 x=0 -> y=4096, ovf=0, udf=0, out_valid 14 cycles after accept (default params).
REQ-038 x=4096 (1.0) -> y=11134+/-4; x=-4096 -> y=1507+/-4; x=2048 (0.5) -> y=6753+/-4.
REQ-039 x=28672 (7.0) -> y=2097151, ovf=1; x=-40960 (-10.0) -> y=0, udf=1.
REQ-040 Back-to-back inputs with out_ready=0 for 5 cycles -> y held stable, in_ready=0 throughout, second input accepted only after the handshake.
REQ-041 rst_n pulsed low during FRAC of x=4096 -> out_valid never rises for that input; the next input x=0 returns 4096.
REQ-042 Random sweep, x uniform in [-8.0, 6.0], against a real-valued model -> error within REQ-030 and correct ovf/udf flags.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, Q-format helpers and constant generators for the CORDIC exp engine
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FRAC = 2'd1,
        INT  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int int_bits(input int w, input int f);
        return w - f;
    endfunction

    function automatic int acc_width(input int w);
        return w + 2;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // round(ln(1 + 2^-i) * 2^f) via ln(1+t) = 2*atanh(t/(2+t)), evaluated in Q60
    function automatic int ln_entry(input int i, input int f);
        logic [127:0] z, z2, term, sum;
        z    = (128'd1 << 60) / ((128'd1 << (i + 1)) + 128'd1);
        z2   = (z * z) >> 60;
        term = z;
        sum  = '0;
        for (int k = 0; k < 24; k++) begin
            sum  = sum + term / 128'(2 * k + 1);
            term = (term * z2) >> 60;
        end
        sum = sum << 1;
        return int'((sum + (128'd1 << (59 - f))) >> (60 - f));
    endfunction

    function automatic int e_scaled(input int f, input bit neg);
        logic [127:0] term, pos, negs;
        term = 128'd1 << 60;
        pos  = '0;
        negs = '0;
        for (int k = 0; k < 30; k++) begin
            if (neg && (k % 2 == 1)) negs = negs + term;
            else                     pos  = pos + term;
            term = term / 128'(k + 1);
        end
        return int'((pos - negs + (128'd1 << (59 - f))) >> (60 - f));
    endfunction

    function automatic int e_pos(input int f);
        return e_scaled(f, 1'b0);
    endfunction

    function automatic int e_neg(input int f);
        return e_scaled(f, 1'b1);
    endfunction

endpackage

// File: rtl/cordic_exp_frac_step.sv
// rtl/cordic_exp_frac_step.sv - one shift-add step of the fractional exponent iteration
module cordic_exp_frac_step #(
    parameter int AW = 24,
    parameter int F  = 12,
    parameter int IW = 4
) (
    input  logic [AW-1:0] acc_i,
    input  logic [F-1:0]  r_i,
    input  logic [F-1:0]  ln_i,
    input  logic [IW-1:0] i_i,
    output logic [AW-1:0] acc_o,
    output logic [F-1:0]  r_o
);

    always_comb begin
        acc_o = acc_i;
        r_o   = r_i;
        if (r_i >= ln_i) begin
            r_o   = r_i - ln_i;
            acc_o = acc_i + (acc_i >> i_i);
        end
    end

endmodule

// File: rtl/cordic_exp_seq.sv
// rtl/cordic_exp_seq.sv - sequential e^x: shift-add fractional part, then multiply by e^+-1 per integer step
module cordic_exp_seq
    import cordic_pkg::*;
#(
    parameter int W = 22,
    parameter int F = 12,
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         udf
);

    localparam int AW = acc_width(W);
    localparam int NW = int_bits(W, F);
    localparam int IW = idx_width(N);
    localparam logic [AW-1:0] ONE     = AW'(1) << F;
    localparam logic [W-1:0]  Y_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MAX = AW'(Y_MAX);
    localparam logic [W-1:0]  E_POS   = W'(e_pos(F));
    localparam logic [W-1:0]  E_NEG   = W'(e_neg(F));

    state_e               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [F-1:0]         r_q, r_d;
    logic signed [NW-1:0] n_q, n_d;
    logic [IW-1:0]        i_q, i_d;
    logic [W-1:0]         y_q, y_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic                 live_q;

    logic [F-1:0] ln_rom [2**IW];
    for (genvar g = 0; g < 2**IW; g++) begin : g_ln
        localparam logic [F-1:0] LN_G = (g < N) ? F'(ln_entry(g, F)) : '0;
        assign ln_rom[g] = LN_G;
    end

    logic [AW-1:0] frac_acc;
    logic [F-1:0]  frac_r;

    cordic_exp_frac_step #(.AW(AW), .F(F), .IW(IW)) u_frac_step (
        .acc_i (acc_q),
        .r_i   (r_q),
        .ln_i  (ln_rom[i_q]),
        .i_i   (i_q),
        .acc_o (frac_acc),
        .r_o   (frac_r)
    );

    logic [2*W-1:0]       prod;
    logic [AW-1:0]        int_acc;
    logic signed [NW-1:0] int_n;

    // acc never exceeds Y_MAX while in INT, so its low W bits are the whole value
    always_comb begin
        prod    = {{W{1'b0}}, acc_q[W-1:0]} * {{W{1'b0}}, (n_q[NW-1] ? E_NEG : E_POS)};
        int_acc = AW'(prod >> F);
        int_n   = n_q[NW-1] ? n_q + NW'(1) : n_q - NW'(1);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        r_d     = r_q;
        n_d     = n_q;
        i_d     = i_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    n_d     = $signed(x[W-1:F]);
                    r_d     = x[F-1:0];
                    acc_d   = ONE;
                    i_d     = '0;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                    state_d = FRAC;
                end
            end
            FRAC: begin
                acc_d = frac_acc;
                r_d   = frac_r;
                i_d   = i_q + IW'(1);
                if (i_q == IW'(N - 1)) begin
                    if (n_q == '0) begin
                        y_d     = frac_acc[W-1:0];
                        state_d = DONE;
                    end else begin
                        state_d = INT;
                    end
                end
            end
            INT: begin
                acc_d = int_acc;
                n_d   = int_n;
                if (int_acc > ACC_MAX) begin
                    ovf_d   = 1'b1;
                    y_d     = Y_MAX;
                    state_d = DONE;
                end else if (int_acc == '0) begin
                    udf_d   = 1'b1;
                    y_d     = '0;
                    state_d = DONE;
                end else if (int_n == '0) begin
                    y_d     = int_acc[W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            r_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            n_q     <= n_d;
            i_q     <= i_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            live_q  <= 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE) && live_q;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule

// File: tb/tb_cordic_exp_seq.sv
// tb/tb_cordic_exp_seq.sv - scoreboard bench for cordic_exp_seq against a real-valued e^x model
module tb_cordic_exp_seq;

    localparam int W = 22;
    localparam int F = 12;
    localparam int N = 12;
    localparam int Y_MAX = (1 << (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         ovf;
    logic         udf;

    cordic_exp_seq #(.W(W), .F(F), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .udf       (udf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int xv;
        int e_y;
        bit e_ovf;
        bit e_udf;
        int tol;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   hold_fixed = -1;

    task automatic chk(input bit ok, input string msg);
        n_chk++;
        if (ok) n_pass++;
        else    $display("FAIL %s", msg);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Directed points use the tight +/-4 band; the sweep band grows with e^x because
    // the fractional stage carries a small relative error that scales with the result.
    task automatic send(input int xv, input bit directed);
        exp_t e;
        real  el;
        int   to;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = W'(xv);
        to = 0;
        while (!in_ready && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (!in_ready) begin
            chk(1'b0, $sformatf("accept_timeout x=%0d got no in_ready want in_ready=1", xv));
            in_valid = 1'b0;
            return;
        end
        el      = $exp(real'(xv) / real'(1 << F)) * real'(1 << F);
        e.xv    = xv;
        e.e_ovf = el > (real'(Y_MAX) + 0.5);
        e.e_udf = el < 0.5;
        e.e_y   = e.e_ovf ? Y_MAX : (e.e_udf ? 0 : int'(el));
        e.tol   = directed ? 4 : 4 + int'(el / 256.0);
        e.lat   = (e.e_ovf || e.e_udf) ? -1 : 2 + N + iabs(xv >>> F);
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = W'($urandom);
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        while ((sb.size() != 0 || out_valid || !in_ready) && to < 2000) begin
            @(negedge clk);
            to++;
        end
        chk(to < 2000, $sformatf("drain_timeout pending=%0d want 0", sb.size()));
    endtask

    initial begin : monitor
        exp_t         cur;
        bit           in_res = 0, have_cur = 0, post_hs = 0, stable_ok = 1;
        logic [W-1:0] hold_y;
        logic         hold_o, hold_u;
        int           waited = 0, tgt = 0, lat = 0, yd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                in_res    = 0;
                post_hs   = 0;
                have_cur  = 0;
            end else begin
                if (post_hs) begin
                    post_hs = 0;
                    chk(out_valid === 1'b0 && in_ready === 1'b1,
                        $sformatf("release got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready));
                end
                if (out_valid) begin
                    if (!in_res) begin
                        in_res    = 1;
                        hold_y    = y;
                        hold_o    = ovf;
                        hold_u    = udf;
                        stable_ok = 1;
                        waited    = 0;
                        tgt       = (hold_fixed >= 0) ? hold_fixed : int'($urandom_range(2));
                        if (sb.size() == 0) begin
                            have_cur = 0;
                            chk(1'b0, $sformatf("unexpected_out_valid y=%0d want no result", y));
                        end else begin
                            cur      = sb.pop_front();
                            have_cur = 1;
                            lat      = cyc - cur.acc_cyc + 1;
                        end
                    end else if (y !== hold_y || ovf !== hold_o || udf !== hold_u) begin
                        stable_ok = 0;
                    end
                    if (in_ready !== 1'b0) stable_ok = 0;
                    if (waited >= tgt) begin
                        out_ready = 1'b1;
                        in_res    = 0;
                        post_hs   = 1;
                        if (have_cur) begin
                            yd = $signed(y);
                            if (cur.e_ovf || cur.e_udf)
                                chk(yd == cur.e_y && ovf == cur.e_ovf && udf == cur.e_udf,
                                    $sformatf("sat x=%0d got y=%0d ovf=%0b udf=%0b want y=%0d ovf=%0b udf=%0b",
                                              cur.xv, yd, ovf, udf, cur.e_y, cur.e_ovf, cur.e_udf));
                            else
                                chk(!ovf && !udf && iabs(yd - cur.e_y) <= cur.tol,
                                    $sformatf("value x=%0d got y=%0d ovf=%0b udf=%0b want y=%0d+/-%0d flags 0",
                                              cur.xv, yd, ovf, udf, cur.e_y, cur.tol));
                            if (cur.lat >= 0)
                                chk(lat == cur.lat, $sformatf("latency x=%0d got %0d want %0d", cur.xv, lat, cur.lat));
                            chk(stable_ok, $sformatf("hold x=%0d got unstable output or in_ready high after %0d stall cycles want stable", cur.xv, waited));
                        end
                    end else begin
                        out_ready = 1'b0;
                        waited++;
                    end
                end else begin
                    out_ready = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got no finish want finish within 50000 cycles");
        $fatal(1);
    end

    initial begin : main
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x_in     = '0;
        repeat (3) @(negedge clk);
        chk(in_ready === 1'b0,  $sformatf("reset_in_ready got %0b want 0", in_ready));
        chk(out_valid === 1'b0, $sformatf("reset_out_valid got %0b want 0", out_valid));
        chk(y === '0,           $sformatf("reset_y got %0d want 0", y));
        chk(ovf === 1'b0 && udf === 1'b0, $sformatf("reset_flags got %0b%0b want 00", ovf, udf));
        rst_n = 1'b1;
        #1;
        chk(in_ready === 1'b0, $sformatf("ready_before_edge got %0b want 0", in_ready));
        @(posedge clk);
        #1;
        chk(in_ready === 1'b1, $sformatf("ready_after_edge got %0b want 1", in_ready));

        send(0, 1);
        send(4096, 1);
        send(-4096, 1);
        send(2048, 1);
        send(28672, 1);
        send(-40960, 1);
        send(-(1 << (W - 1)), 1);
        send((1 << (W - 1)) - 1, 1);

        wait_idle();
        hold_fixed = 5;
        send(1234, 1);
        send(-5000, 0);
        wait_idle();
        hold_fixed = -1;

        @(negedge clk);
        in_valid = 1'b1;
        x_in     = W'(4096);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk(out_valid === 1'b0 && in_ready === 1'b0 && y === '0,
            $sformatf("abort_reset got out_valid=%0b in_ready=%0b y=%0d want 0/0/0", out_valid, in_ready, y));
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 1);

        for (int k = 0; k < 40; k++)
            send(int'($urandom_range(14 * 4096)) - 8 * 4096, 0);

        wait_idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
